// File: rtl/memi_fetch.sv
// Instruction memory with a multi-lane fetch port and a runtime write port.
// A post-reset sweep writes INIT_WORD to every word before fetch opens.
module memi_fetch #(
   parameter int unsigned          INST_LEN  = 16,
   parameter int unsigned          DEPTH_LOG = 5,
   parameter int unsigned          FETCH_W   = 2,
   parameter logic [INST_LEN-1:0]  INIT_WORD = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          o_init_done,
   input  logic                          i_req_valid,
   output logic                          o_req_ready,
   input  logic [DEPTH_LOG-1:0]          i_req_addr,
   output logic                          o_resp_valid,
   input  logic                          i_resp_ready,
   output logic [DEPTH_LOG-1:0]          o_resp_addr,
   output logic [FETCH_W*INST_LEN-1:0]   o_resp_data,
   input  logic                          i_flush,
   input  logic                          i_wr_en,
   input  logic [DEPTH_LOG-1:0]          i_wr_addr,
   input  logic [INST_LEN-1:0]           i_wr_data
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG;

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                        r_state, w_state_next;
   logic [DEPTH_LOG-1:0]          r_init_cnt, w_init_cnt_next;
   logic [INST_LEN-1:0]           r_mem [DEPTH];
   logic                          r_resp_valid;
   logic [DEPTH_LOG-1:0]          r_resp_addr;
   logic [FETCH_W*INST_LEN-1:0]   r_resp_data;
   logic [FETCH_W*INST_LEN-1:0]   w_fetch_data;
   logic                          w_accept;

   always_comb begin
      w_state_next    = r_state;
      w_init_cnt_next = r_init_cnt;
      unique case (r_state)
         StInit: begin
            w_init_cnt_next = r_init_cnt + DEPTH_LOG'(1);
            if (&r_init_cnt) begin
               w_state_next = StRun;
            end
         end
         StRun: begin
            w_state_next = StRun;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StInit;
         r_init_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_init_cnt <= w_init_cnt_next;
      end
   end

   assign o_init_done = (r_state == StRun);
   assign o_req_ready = (r_state == StRun) & ~i_flush & (~r_resp_valid | i_resp_ready);
   assign w_accept    = i_req_valid & o_req_ready;

   // Lane addresses wrap modulo DEPTH through natural DEPTH_LOG-bit overflow.
   always_comb begin
      w_fetch_data = '0;
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         w_fetch_data[i*INST_LEN +: INST_LEN] = r_mem[i_req_addr + DEPTH_LOG'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_resp_addr  <= '0;
         r_resp_data  <= '0;
      end else if (w_accept) begin
         r_resp_valid <= 1'b1;
         r_resp_addr  <= i_req_addr;
         r_resp_data  <= w_fetch_data;
      end else if (i_flush || i_resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   // No reset on the array; a fetch on the same edge as a write sees the old word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == StInit) begin
            r_mem[r_init_cnt] <= INIT_WORD;
         end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
         end
      end
   end

   assign o_resp_valid = r_resp_valid;
   assign o_resp_addr  = r_resp_addr;
   assign o_resp_data  = r_resp_data;

endmodule

// File: tb/tb_memi_fetch.sv
// Scoreboard bench for memi_fetch: stimulus queues expected responses,
// a negedge monitor pops and compares every response the consumer takes.
module tb_memi_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        o_init_done;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [4:0]  i_req_addr;
   logic        o_resp_valid;
   logic        i_resp_ready;
   logic [4:0]  o_resp_addr;
   logic [31:0] o_resp_data;
   logic        i_flush;
   logic        i_wr_en;
   logic [4:0]  i_wr_addr;
   logic [15:0] i_wr_data;

   int checks = 0;
   int errors = 0;
   logic [4:0]  q_addr[$];
   logic [31:0] q_data[$];

   always #5 clk = ~clk;

   memi_fetch #(
      .INST_LEN  (16),
      .DEPTH_LOG (5),
      .FETCH_W   (2),
      .INIT_WORD (16'h0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .o_init_done  (o_init_done),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_addr   (i_req_addr),
      .o_resp_valid (o_resp_valid),
      .i_resp_ready (i_resp_ready),
      .o_resp_addr  (o_resp_addr),
      .o_resp_data  (o_resp_data),
      .i_flush      (i_flush),
      .i_wr_en      (i_wr_en),
      .i_wr_addr    (i_wr_addr),
      .i_wr_data    (i_wr_data)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   // Monitor: a response is consumed when valid & ready and not squashed.
   always @(negedge clk) begin
      if (!rst && o_resp_valid && i_resp_ready && !i_flush) begin
         if (q_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got addr %0d data 0x%0h required none",
                     o_resp_addr, o_resp_data);
         end else begin
            chk("resp_addr", 32'(o_resp_addr), 32'(q_addr.pop_front()));
            chk("resp_data", o_resp_data, q_data.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [15:0] d);
      i_wr_en   = 1'b1;
      i_wr_addr = a;
      i_wr_data = d;
      step();
      i_wr_en   = 1'b0;
   endtask

   task automatic fetch(input logic [4:0] a, input logic [31:0] exp);
      int n = 0;
      i_req_valid = 1'b1;
      i_req_addr  = a;
      sample();
      while (!o_req_ready && n < 20) begin
         step();
         sample();
         n++;
      end
      checks++;
      if (!o_req_ready) begin
         errors++;
         $display("FAIL fetch_ready: got 0 required 1 (addr %0d)", a);
      end else begin
         q_addr.push_back(a);
         q_data.push_back(exp);
      end
      step();
      i_req_valid = 1'b0;
   endtask

   // Expects rst just released; requests are held valid to prove nothing is accepted.
   task automatic sweep_check();
      i_req_valid = 1'b1;
      i_req_addr  = 5'd0;
      for (int i = 0; i < 32; i++) begin
         sample();
         chk("sweep_init_done", 32'(o_init_done), 32'd0);
         chk("sweep_req_ready", 32'(o_req_ready), 32'd0);
         step();
      end
      i_req_valid = 1'b0;
      sample();
      chk("init_done_cycle33", 32'(o_init_done), 32'd1);
      step();
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: got no finish required finish within 50000 time units");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      i_req_valid  = 1'b0;
      i_req_addr   = '0;
      i_resp_ready = 1'b1;
      i_flush      = 1'b0;
      i_wr_en      = 1'b0;
      i_wr_addr    = '0;
      i_wr_data    = '0;

      sample();
      chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      chk("rst_init_done", 32'(o_init_done), 32'd0);
      chk("rst_req_ready", 32'(o_req_ready), 32'd0);
      step();
      rst = 1'b0;
      sweep_check();

      fetch(5'd0, 32'h0000_0000);

      do_write(5'd4, 16'h1111);
      do_write(5'd5, 16'h2222);
      fetch(5'd4, 32'h2222_1111);
      sample();
      chk("latency_resp_valid", 32'(o_resp_valid), 32'd1);
      chk("latency_resp_addr", 32'(o_resp_addr), 32'd4);
      step();

      do_write(5'd31, 16'hAAAA);
      do_write(5'd0, 16'hBBBB);
      fetch(5'd31, 32'hBBBB_AAAA);

      // Backpressure then full-throughput drain.
      do_write(5'd8, 16'h5555);
      do_write(5'd9, 16'h6666);
      do_write(5'd10, 16'h7777);
      i_resp_ready = 1'b0;
      fetch(5'd8, 32'h6666_5555);
      i_req_valid = 1'b1;
      i_req_addr  = 5'd9;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("bp_req_ready", 32'(o_req_ready), 32'd0);
         chk("bp_resp_valid", 32'(o_resp_valid), 32'd1);
         chk("bp_resp_data", o_resp_data, 32'h6666_5555);
         chk("bp_resp_addr", 32'(o_resp_addr), 32'd8);
         step();
      end
      i_resp_ready = 1'b1;
      sample();
      chk("b2b_req_ready0", 32'(o_req_ready), 32'd1);
      q_addr.push_back(5'd9);
      q_data.push_back(32'h7777_6666);
      step();
      i_req_addr = 5'd10;
      sample();
      chk("b2b_resp_valid1", 32'(o_resp_valid), 32'd1);
      chk("b2b_req_ready1", 32'(o_req_ready), 32'd1);
      q_addr.push_back(5'd10);
      q_data.push_back(32'h0000_7777);
      step();
      i_req_valid = 1'b0;
      sample();
      chk("b2b_resp_valid2", 32'(o_resp_valid), 32'd1);
      step();
      sample();
      chk("drain_resp_valid", 32'(o_resp_valid), 32'd0);
      step();

      // Flush the cycle after an accept: the response is squashed, not consumed.
      fetch(5'd4, 32'h2222_1111);
      i_flush     = 1'b1;
      i_req_valid = 1'b1;
      i_req_addr  = 5'd0;
      sample();
      chk("flush_req_ready", 32'(o_req_ready), 32'd0);
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
      step();
      i_flush     = 1'b0;
      i_req_valid = 1'b0;
      sample();
      chk("flush_resp_valid", 32'(o_resp_valid), 32'd0);
      step();

      // Write and fetch on the same edge read the old word.
      i_wr_en   = 1'b1;
      i_wr_addr = 5'd6;
      i_wr_data = 16'h3333;
      fetch(5'd6, 32'h0000_0000);
      i_wr_en   = 1'b0;
      fetch(5'd6, 32'h0000_3333);
      step();

      // Reset during backpressure, then again mid-sweep.
      i_resp_ready = 1'b0;
      fetch(5'd4, 32'h2222_1111);
      rst = 1'b1;
      q_addr.delete();
      q_data.delete();
      step();
      rst = 1'b0;
      sample();
      chk("rst_bp_resp_valid", 32'(o_resp_valid), 32'd0);
      chk("rst_bp_resp_data", o_resp_data, 32'h0);
      chk("rst_bp_resp_addr", 32'(o_resp_addr), 32'd0);
      chk("rst_bp_init_done", 32'(o_init_done), 32'd0);
      step();
      for (int i = 0; i < 8; i++) begin
         sample();
         chk("midsweep_init_done", 32'(o_init_done), 32'd0);
         step();
      end
      rst = 1'b1;
      step();
      rst          = 1'b0;
      i_resp_ready = 1'b1;
      sweep_check();

      // The fresh sweep must have cleared earlier program data.
      fetch(5'd4, 32'h0000_0000);
      fetch(5'd31, 32'h0000_0000);
      step();
      step();
      sample();
      chk("sb_empty", 32'(q_data.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
